// File: rtl/axis_interpolator_if.sv
// AXI-Stream handshake bundle (valid/ready/data) used on both sides of the interpolator.
interface axis_interpolator_if #(
   parameter int unsigned W = 32
) ();
   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_interpolator.sv
// AXI-Stream upsampler: emits 2^L linearly interpolated samples per input segment,
// lagging the input stream by one sample.
module axis_interpolator #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [4:0]             log_interp,
   axis_interpolator_if.slave     s_axis,
   axis_interpolator_if.master    m_axis
);
   localparam int unsigned W     = AXIS_TDATA_WIDTH;
   localparam int unsigned ACC_W = W + 17;
   localparam int unsigned PH_W  = 17;

   typedef enum logic [1:0] {EMPTY, PRIME, RUN} state_t;

   state_t                  state, state_next;
   logic signed [W-1:0]     curr;
   logic signed [W:0]       delta;
   logic signed [ACC_W-1:0] acc;
   logic [PH_W-1:0]         phase;
   logic [4:0]              lseg;

   logic [4:0]              lclamp;
   logic [PH_W-1:0]         phase_last;
   logic                    load, seg_end, ready, in_fire, start_seg;
   logic signed [W:0]       diff;
   logic signed [ACC_W-1:0] curr_ext;

   always_comb begin
      lclamp     = (log_interp > 5'd16) ? 5'd16 : log_interp;
      phase_last = (PH_W'(1) << lseg) - PH_W'(1);
      load       = ~m_axis.tvalid | m_axis.tready;
      seg_end    = (state == RUN) && (phase == phase_last) && load;
      diff       = {s_axis.tdata[W-1], s_axis.tdata} - {curr[W-1], curr};
      curr_ext   = {{17{curr[W-1]}}, curr};
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) state <= EMPTY;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         EMPTY: begin
            ready = 1'b1;
            if (s_axis.tvalid) state_next = PRIME;
         end
         PRIME: begin
            ready = 1'b1;
            if (s_axis.tvalid) state_next = RUN;
         end
         RUN: begin
            // input is only taken in the cycle that emits the segment's last sample
            ready = seg_end;
            if (seg_end && !s_axis.tvalid) state_next = PRIME;
         end
         default: state_next = EMPTY;
      endcase
   end

   assign s_axis.tready = ready;
   assign in_fire       = s_axis.tvalid & ready;
   assign start_seg     = in_fire & (state != EMPTY);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis.tvalid <= 1'b0;
         m_axis.tdata  <= '0;
         curr          <= '0;
         delta         <= '0;
         acc           <= '0;
         phase         <= '0;
         lseg          <= '0;
      end else begin
         if (state == RUN && load) begin
            m_axis.tdata  <= W'(acc >>> lseg);
            m_axis.tvalid <= 1'b1;
            acc           <= acc + ACC_W'(delta);
            phase         <= phase + PH_W'(1);
         end else if (m_axis.tvalid && m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
         end
         if (in_fire) curr <= s_axis.tdata;
         // segment start overrides the RUN step above when both land in one cycle
         if (start_seg) begin
            delta <= diff;
            acc   <= curr_ext <<< lclamp;
            phase <= '0;
            lseg  <= lclamp;
         end
      end
   end
endmodule

// File: tb/tb_axis_interpolator.sv
// Directed plus randomized checks of axis_interpolator (W=16) against an arithmetic
// reference model of the interpolated output stream.
module tb_axis_interpolator;
   logic       clk = 1'b0;
   logic       aresetn;
   logic [4:0] li;

   axis_interpolator_if #(.W(16)) s_if ();
   axis_interpolator_if #(.W(16)) m_if ();

   axis_interpolator #(.AXIS_TDATA_WIDTH(16)) dut (
      .aclk       (clk),
      .aresetn    (aresetn),
      .log_interp (li),
      .s_axis     (s_if.slave),
      .m_axis     (m_if.master)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_q[$];
   bit   have_prev;
   int   prev;
   logic last_in, last_out;
   int   last_data;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // reference: segment prev->x yields prev + floor((x-prev)*k/N), k=0..N-1
   task automatic model_in(input int x);
      if (have_prev) begin
         int l = (li > 5'd16) ? 16 : int'(li);
         longint n = longint'(1) << l;
         for (int k = 0; k < int'(n); k++) begin
            longint d = (longint'(x) - longint'(prev)) * longint'(k);
            longint q = d / n;
            if ((d % n != 0) && d < 0) q = q - 1;
            exp_q.push_back(int'(longint'(prev) + q));
         end
      end
      prev      = x;
      have_prev = 1'b1;
   endtask

   task automatic step(input logic sv, input int sd, input logic mr);
      @(negedge clk);
      s_if.tvalid = sv;
      s_if.tdata  = 16'(sd);
      m_if.tready = mr;
      #1;
      last_in  = sv & s_if.tready;
      last_out = m_if.tvalid & mr;
      if (last_out === 1'b1) begin
         last_data = int'($signed(m_if.tdata));
         chk("unexpected_output", (exp_q.size() > 0) ? 1 : 0, 1);
         if (exp_q.size() > 0) chk("tdata", last_data, exp_q.pop_front());
      end
      if (last_in === 1'b1) model_in(sd);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x);
      int t = 0;
      do begin
         step(1'b1, x, 1'b1);
         t++;
      end while (last_in !== 1'b1 && t < 200);
      chk("send_accept", last_in, 1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() > 0 && t < 300) begin
         step(1'b0, 0, 1'b1);
         t++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      step(1'b0, 0, 1'b1);
      aresetn = 1'b1;
      exp_q.delete();
      have_prev = 1'b0;
   endtask

   initial begin
      int mono_prev, mono_cnt, t, idx;
      int vals[200];

      aresetn     = 1'b0;
      li          = 5'd0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b1;
      step(1'b0, 0, 1'b1);
      do_reset();
      chk("reset_tvalid", m_if.tvalid, 0);
      chk("reset_tdata", $signed(m_if.tdata), 0);
      chk("reset_tready", s_if.tready, 1);

      // L=2, 0,8,16 -> 0,2,...,14 then tvalid drops
      li = 5'd2;
      send(0); send(8); send(16);
      drain();
      chk("underrun_tvalid", m_if.tvalid, 0);
      chk("last_out_value", last_data, 14);

      // L=1, floor rounding on negative delta
      do_reset();
      li = 5'd1;
      send(10); send(-10); send(-11);
      drain();
      chk("neg_floor_last", last_data, -11);

      // L=0 passthrough at full rate
      do_reset();
      li = 5'd0;
      step(1'b1, 5, 1'b1); chk("l0_acc5", last_in, 1);
      step(1'b1, 6, 1'b1); chk("l0_acc6", last_in, 1);
      step(1'b1, 7, 1'b1); chk("l0_acc7", last_in, 1);
      step(1'b0, 0, 1'b1); chk("l0_out_a", last_out, 1);
      step(1'b0, 0, 1'b1); chk("l0_out_b", last_out, 1);
      chk("l0_left", exp_q.size(), 0);

      // backpressure holds output and blocks input
      do_reset();
      li = 5'd2;
      send(0); send(8);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 0, 1'b0);
         chk("bp_tdata", $signed(m_if.tdata), 2);
         chk("bp_tvalid", m_if.tvalid, 1);
         chk("bp_tready", s_if.tready, 0);
      end
      drain();
      chk("bp_last", last_data, 6);

      // full-scale ramp, no wrap
      do_reset();
      li = 5'd4;
      send(-32768); send(32767);
      mono_prev = -32769; mono_cnt = 0; t = 0;
      while (mono_cnt < 16 && t < 100) begin
         step(1'b0, 0, 1'b1);
         t++;
         if (last_out === 1'b1) begin
            chk("monotonic", (last_data > mono_prev) ? 1 : 0, 1);
            mono_prev = last_data;
            mono_cnt++;
         end
      end
      chk("ramp_count", mono_cnt, 16);
      chk("ramp_end", last_data, 28671);

      // log_interp above 16 clamps, then a mid-run reset restarts cleanly
      do_reset();
      li = 5'd17;
      send(0); send(16384);
      for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
      chk("clamp_k6", last_data, 1);
      do_reset();
      chk("midrst_tvalid", m_if.tvalid, 0);
      chk("midrst_tready", s_if.tready, 1);
      li = 5'd1;
      send(4); send(8);
      drain();
      chk("midrst_last", last_data, 6);

      // randomized traffic with L changing on the fly
      do_reset();
      for (int i = 0; i < 200; i++) vals[i] = int'($urandom_range(0, 65535)) - 32768;
      idx = 0; t = 0;
      li = 5'($urandom_range(0, 3));
      while (idx < 200 && t < 6000) begin
         if ($urandom_range(0, 19) == 0) li = 5'($urandom_range(0, 3));
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, vals[idx],
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
         if (last_in === 1'b1) idx++;
         t++;
      end
      chk("rand_sent", idx, 200);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
